// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave transmit path.
// The CRC helper is only referenced when SPI_TX_CRC16_EN is defined.
package spi_pkg;

  localparam logic [7:0]  SPI_FILL_BYTE = 8'hFF;
  localparam logic [15:0] CRC16_POLY    = 16'h1021;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } tx_entry_t;

  // Origin of the byte occupying the current 8-cycle slot.
  typedef enum logic [1:0] {
    SRC_FILL,
    SRC_FIFO,
    SRC_CRC_HI,
    SRC_CRC_LO
  } slot_src_t;

  // CRC16-CCITT, MSB-first, no reflection; folds one byte into crc.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/spi_tx_fifo.sv
// Synchronous FIFO of tx_entry_t; pointers carry one wrap bit so full and
// empty are distinguishable without a separate counter.
module spi_tx_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  tx_entry_t                push_entry,
  input  logic                     pop,
  output tx_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  tx_entry_t      mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, so clearing them is a full flush.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);

endmodule

// File: rtl/spi_tx_buffer.sv
// SPI slave transmitter: queues response bytes and shifts them out MSB-first
// in 8-cycle slots, sending FILL when idle. Optional CRC16 trailer: SPI_TX_CRC16_EN.
module spi_tx_buffer
  import spi_pkg::*;
#(
  parameter int         DEPTH = 4,
  parameter logic [7:0] FILL  = SPI_FILL_BYTE
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       IsInitialized,
  input  logic       CS,
  input  logic [7:0] Data,
  input  logic       Valid,
  input  logic       Last,
  output logic       Ready,
  output logic       DO,
  output logic       Busy,
  output logic       Underrun
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic            rst;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  tx_entry_t       head;
  logic            load;
  logic            pop;
  slot_src_t       load_src;
  logic [7:0]      load_byte;
  slot_src_t       cur_src;
  logic [7:0]      shift;
  logic [2:0]      bit_cnt;
  logic            crc_busy;

  assign rst  = reset || !IsInitialized;
  assign load = !CS && (bit_cnt == 3'd7);

  spi_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (CLK),
    .rst        (rst),
    .push       (Valid && Ready),
    .push_entry ('{last: Last, data: Data}),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

`ifdef SPI_TX_CRC16_EN
  logic [15:0] crc;
  logic [1:0]  crc_pend;   // 2: CRC high byte due next slot, 1: low byte due

  always_ff @(posedge CLK) begin
    if (rst || (CS && (crc_pend != 2'd0 || cur_src == SRC_CRC_HI))) begin
      crc      <= '0;
      crc_pend <= 2'd0;
    end else if (load) begin
      case (load_src)
        SRC_FIFO: begin
          crc <= crc16_byte(crc, head.data);
          if (head.last) crc_pend <= 2'd2;
        end
        SRC_CRC_HI: crc_pend <= 2'd1;
        SRC_CRC_LO: begin
          crc_pend <= 2'd0;
          crc      <= '0;
        end
        default: ;
      endcase
    end
  end

  assign crc_busy = (crc_pend != 2'd0);
`else
  logic unused_last;
  assign unused_last = head.last;
  assign crc_busy    = 1'b0;
`endif

  // NOTE: every output of this block gets a default first so no path can
  // leave a value held, which would infer a latch.
  always_comb begin
    load_src  = SRC_FILL;
    load_byte = FILL;
`ifdef SPI_TX_CRC16_EN
    if (crc_pend == 2'd2) begin
      load_src  = SRC_CRC_HI;
      load_byte = crc[15:8];
    end else if (crc_pend == 2'd1) begin
      load_src  = SRC_CRC_LO;
      load_byte = crc[7:0];
    end else
`endif
    if (!empty) begin
      load_src  = SRC_FIFO;
      load_byte = head.data;
    end
    pop = load && (load_src == SRC_FIFO);
  end

  always_ff @(posedge CLK) begin
    if (rst || CS) begin
      shift    <= 8'hFF;
      bit_cnt  <= 3'd7;
      cur_src  <= SRC_FILL;
      Underrun <= 1'b0;
    end else if (bit_cnt == 3'd7) begin
      shift    <= load_byte;
      bit_cnt  <= 3'd0;
      cur_src  <= load_src;
      Underrun <= (load_src == SRC_FILL);
    end else begin
      shift    <= {shift[6:0], 1'b1};
      bit_cnt  <= bit_cnt + 3'd1;
      Underrun <= 1'b0;
    end
  end

  assign DO    = shift[7];
  assign Ready = !full;
  assign Busy  = (count != '0) || (cur_src != SRC_FILL && bit_cnt != 3'd7) || crc_busy;

endmodule

// File: tb/tb_spi_tx_buffer.sv
// Self-checking bench for spi_tx_buffer: directed scenarios plus random
// traffic against a byte-queue model; CRC trailer checked when SPI_TX_CRC16_EN is set.
module tb_spi_tx_buffer;

  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       IsInitialized = 1'b1;
  logic       CS = 1'b1;
  logic [7:0] Data = 8'h00;
  logic       Valid = 1'b0;
  logic       Last = 1'b0;
  logic       Ready;
  logic       DO;
  logic       Busy;
  logic       Underrun;

  spi_tx_buffer #(.DEPTH(DEPTH), .FILL(8'hFF)) dut (
    .CLK           (CLK),
    .reset         (reset),
    .IsInitialized (IsInitialized),
    .CS            (CS),
    .Data          (Data),
    .Valid         (Valid),
    .Last          (Last),
    .Ready         (Ready),
    .DO            (DO),
    .Busy          (Busy),
    .Underrun      (Underrun)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit check_en = 1'b1;

  // Model: pending bytes, byte on the wire, and how many of its bits have
  // been presented (-1 = between slots / deselected).
  byte unsigned q[$];
  logic [7:0]   m_cur = 8'hFF;
  int           m_pos = -1;
  bit           m_src = 1'b0;
  bit           m_und = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge(input bit v, input logic [7:0] d, input bit cs, input bit r);
    bit pre_full;
    bit pre_empty;
    pre_full  = (q.size() == DEPTH);
    pre_empty = (q.size() == 0);
    m_und = 1'b0;
    if (r) begin
      q.delete();
      m_pos = -1;
      m_cur = 8'hFF;
      m_src = 1'b0;
      return;
    end
    if (cs) begin
      m_pos = -1;
      m_cur = 8'hFF;
      m_src = 1'b0;
    end else if (m_pos == -1 || m_pos == 7) begin
      if (!pre_empty) begin
        m_cur = q.pop_front();
        m_src = 1'b1;
      end else begin
        m_cur = 8'hFF;
        m_src = 1'b0;
        m_und = 1'b1;
      end
      m_pos = 0;
    end else begin
      m_pos++;
    end
    if (v && !pre_full) q.push_back(d);
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit l, input bit cs,
                      input bit r, input bit init = 1'b1);
    logic exp_do;
    logic exp_busy;
    Valid = v; Data = d; Last = l; CS = cs; reset = r; IsInitialized = init;
    @(posedge CLK);
    cyc++;
    model_edge(v, d, cs, r || !init);
    #1;
    if (check_en) begin
      exp_do   = (m_pos < 0) ? 1'b1 : m_cur[7 - m_pos];
      exp_busy = (q.size() != 0) || (m_src && m_pos >= 0 && m_pos != 7);
      check("do", DO, exp_do);
      check("ready", Ready, q.size() < DEPTH);
      check("busy", Busy, exp_busy);
      check("underrun", Underrun, m_und);
    end
  endtask

  logic [15:0] bits16;
  logic [15:0] und_mask;
  logic [7:0]  bits8;

  initial begin
    // Reset state
    step(0, 8'h00, 0, 1, 1);
    step(0, 8'h00, 0, 1, 1);
    check("reset_do", DO, 1'b1);
    check("reset_ready", Ready, 1'b1);
    step(0, 8'h00, 0, 1, 0);

    // Empty FIFO, CS low for 16 cycles: all ones, Underrun on cycles 1 and 9
    bits16 = '0; und_mask = '0;
    for (int i = 0; i < 16; i++) begin
      step(0, 8'h00, 0, 0, 0);
      bits16[15 - i] = DO;
      und_mask[i]    = Underrun;
      check("idle_busy", Busy, 1'b0);
    end
    check("idle_do_bits", bits16, 16'hFFFF);
    check("idle_underrun_cycles", und_mask, 16'h0101);

    // 0xA5, 0x3C queued while deselected, then shifted
    step(0, 8'h00, 0, 1, 0);
    step(1, 8'hA5, 0, 1, 0);
    step(1, 8'h3C, 0, 1, 0);
    for (int i = 0; i < 24; i++) begin
      step(0, 8'h00, 0, 0, 0);
      if (i < 16) bits16[15 - i] = DO;
      if (i == 14) check("busy_before_last_bit", Busy, 1'b1);
      if (i == 15) check("busy_at_last_bit", Busy, 1'b0);
    end
    check("a5_3c_stream", bits16, 16'hA53C);

    // Overfill with CS high: Ready drops after 4th accept, 5th waits for a pop
    step(0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 8'h11 + 8'(i), 0, 1, 0);
    check("ready_full", Ready, 1'b0);
    step(1, 8'h15, 0, 1, 0);
    step(1, 8'h15, 0, 1, 0);
    check("ready_held_off", Ready, 1'b0);
    step(1, 8'h15, 0, 0, 0);
    check("ready_after_pop", Ready, 1'b1);
    step(1, 8'h15, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(0, 8'h00, 0, 0, 0);

    // Abandon 0x00 after 3 bits; 0x5A starts at the first edge back
    step(0, 8'h00, 0, 1, 0);
    step(1, 8'h00, 0, 1, 0);
    step(1, 8'h5A, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 1, 0);
    bits8 = '0;
    for (int i = 0; i < 8; i++) begin
      step(0, 8'h00, 0, 0, 0);
      bits8[7 - i] = DO;
    end
    check("resume_byte", bits8, 8'h5A);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 0, 0, 0);

    // Reset mid-byte with 3 bytes still queued
    step(0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 8'hC1 + 8'(i), 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 1);
    check("midreset_do", DO, 1'b1);
    check("midreset_ready", Ready, 1'b1);
    check("midreset_busy", Busy, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(0, 8'h00, 0, 0, 0);
      bits16[15 - i] = DO;
    end
    check("post_reset_stream", bits16, 16'hFFFF);

    // IsInitialized low behaves as reset
    step(0, 8'h00, 0, 1, 0);
    step(1, 8'h42, 0, 1, 0);
    step(0, 8'h00, 0, 0, 0, 0);
    check("uninit_busy", Busy, 1'b0);
    step(0, 8'h00, 0, 0, 0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 0,
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 99) != 0));
    end

`ifdef SPI_TX_CRC16_EN
    // "123456789" with Last on '9': expect CRC 0x31C3 then fill
    begin
      byte unsigned msg[9];
      logic [7:0]   slot [12];
      int           idx;
      bit           rdy;
      msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      check_en = 1'b0;
      step(0, 8'h00, 0, 1, 1);
      idx = 0;
      for (int i = 0; i < 4; i++) begin
        step(1, msg[idx], 0, 1, 0);
        idx++;
      end
      for (int e = 0; e < 96; e++) begin
        rdy = Ready;
        if (idx < 9) step(1, msg[idx], (idx == 8), 0, 0);
        else         step(0, 8'h00, 0, 0, 0);
        if (idx < 9 && rdy) idx++;
        slot[e / 8][7 - (e % 8)] = DO;
        if (e == 8 * 10 + 3) check("crc_lo_busy", Busy, 1'b1);
        if (e == 8 * 11 + 3) check("fill_after_crc_busy", Busy, 1'b0);
      end
      for (int s = 0; s < 9; s++) check("crc_msg_byte", slot[s], msg[s]);
      check("crc_hi", slot[9], 8'h31);
      check("crc_lo", slot[10], 8'hC3);
      check("crc_then_fill", slot[11], 8'hFF);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
